// File: rtl/vga_timing_analyzer.sv
// Measures active size, totals and sync polarities of raw VGA timing, qualifies
// them over consecutive identical frames and flags loss of vsync.
module vga_timing_analyzer #(
   parameter int HBITS          = 11,
   parameter int VBITS          = 10,
   parameter int STABLE_FRAMES  = 3,
   parameter int TIMEOUT_CYCLES = 2000000
) (
   input  logic             clk_vga,
   input  logic             resetn,
   input  logic             vga_ce,
   input  logic             vga_hs,
   input  logic             vga_vs,
   input  logic             vga_de,
   output logic [HBITS-1:0] fb_width,
   output logic [VBITS-1:0] fb_height,
   output logic [HBITS-1:0] h_total,
   output logic [VBITS-1:0] v_total,
   output logic             hs_pol,
   output logic             vs_pol,
   output logic             fb_size_valid,
   output logic             mode_change,
   output logic             no_signal
);

   // state     | meaning
   // NO_SIGNAL | no vsync seen since reset or timeout; next vsync edge is partial
   // ACQUIRE   | collecting candidates until STABLE_FRAMES identical in a row
   // LOCKED    | reported values valid; reloaded when a new mode qualifies

   typedef enum logic [1:0] {
      S_NO_SIGNAL,
      S_ACQUIRE,
      S_LOCKED
   } state_t;

   typedef struct packed {
      logic [HBITS-1:0] w;
      logic [VBITS-1:0] h;
      logic [HBITS-1:0] ht;
      logic [VBITS-1:0] vt;
      logic             hp;
      logic             vp;
   } cand_t;

   localparam int          TBITS      = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [3:0]  STABLE_TGT = 4'(STABLE_FRAMES);
   localparam logic [TBITS-1:0] TMO   = TBITS'(TIMEOUT_CYCLES);

   function automatic logic [HBITS-1:0] inc_h(input logic [HBITS-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   function automatic logic [VBITS-1:0] inc_v(input logic [VBITS-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   state_t           state, state_nx;
   logic             hs_q, hs_q_nx, vs_q, vs_q_nx;
   logic [HBITS-1:0] de_cnt, de_cnt_nx;
   logic [HBITS-1:0] hcnt, hcnt_nx;
   logic [HBITS-1:0] hs_hi, hs_hi_nx;
   logic [HBITS-1:0] max_w, max_w_nx;
   logic [HBITS-1:0] last_htot, last_htot_nx;
   logic             last_hpol, last_hpol_nx;
   logic [VBITS-1:0] act_lines, act_lines_nx;
   logic [VBITS-1:0] vlines, vlines_nx;
   logic [VBITS-1:0] vs_hi_lines, vs_hi_lines_nx;
   logic [TBITS-1:0] tcnt, tcnt_nx;
   logic [3:0]       stable_cnt, stable_cnt_nx, stable_calc;
   cand_t            prev_cand, prev_cand_nx;
   cand_t            rep, rep_nx;
   cand_t            cand;
   logic             valid_nx, mode_change_nx, no_signal_nx;
   logic             hs_rise, vs_rise;

   assign hs_rise = vga_hs & ~hs_q;
   assign vs_rise = vga_vs & ~vs_q;

   assign fb_width  = rep.w;
   assign fb_height = rep.h;
   assign h_total   = rep.ht;
   assign v_total   = rep.vt;
   assign hs_pol    = rep.hp;
   assign vs_pol    = rep.vp;

   always_ff @(posedge clk_vga) begin
      if (!resetn) begin
         state         <= S_NO_SIGNAL;
         hs_q          <= 1'b0;
         vs_q          <= 1'b0;
         de_cnt        <= '0;
         hcnt          <= '0;
         hs_hi         <= '0;
         max_w         <= '0;
         last_htot     <= '0;
         last_hpol     <= 1'b0;
         act_lines     <= '0;
         vlines        <= '0;
         vs_hi_lines   <= '0;
         tcnt          <= '0;
         stable_cnt    <= '0;
         prev_cand     <= '0;
         rep           <= '0;
         fb_size_valid <= 1'b0;
         mode_change   <= 1'b0;
         no_signal     <= 1'b1;
      end else begin
         state         <= state_nx;
         hs_q          <= hs_q_nx;
         vs_q          <= vs_q_nx;
         de_cnt        <= de_cnt_nx;
         hcnt          <= hcnt_nx;
         hs_hi         <= hs_hi_nx;
         max_w         <= max_w_nx;
         last_htot     <= last_htot_nx;
         last_hpol     <= last_hpol_nx;
         act_lines     <= act_lines_nx;
         vlines        <= vlines_nx;
         vs_hi_lines   <= vs_hi_lines_nx;
         tcnt          <= tcnt_nx;
         stable_cnt    <= stable_cnt_nx;
         prev_cand     <= prev_cand_nx;
         rep           <= rep_nx;
         fb_size_valid <= valid_nx;
         mode_change   <= mode_change_nx;
         no_signal     <= no_signal_nx;
      end
   end

   always_comb begin
      state_nx        = state;
      hs_q_nx         = hs_q;
      vs_q_nx         = vs_q;
      de_cnt_nx       = de_cnt;
      hcnt_nx         = hcnt;
      hs_hi_nx        = hs_hi;
      max_w_nx        = max_w;
      last_htot_nx    = last_htot;
      last_hpol_nx    = last_hpol;
      act_lines_nx    = act_lines;
      vlines_nx       = vlines;
      vs_hi_lines_nx  = vs_hi_lines;
      tcnt_nx         = tcnt;
      stable_cnt_nx   = stable_cnt;
      stable_calc     = stable_cnt;
      prev_cand_nx    = prev_cand;
      rep_nx          = rep;
      cand            = '0;
      valid_nx        = fb_size_valid;
      mode_change_nx  = 1'b0;
      no_signal_nx    = no_signal;

      if (vga_ce) begin
         hs_q_nx = vga_hs;
         vs_q_nx = vga_vs;

         // The boundary cycle is the first cycle of the new line, so the
         // per-line counters restart with its contribution rather than zero.
         if (hs_rise) begin
            max_w_nx     = (de_cnt > max_w) ? de_cnt : max_w;
            if (de_cnt != '0) act_lines_nx = inc_v(act_lines);
            vlines_nx    = inc_v(vlines);
            if (vga_vs) vs_hi_lines_nx = inc_v(vs_hi_lines);
            last_htot_nx = hcnt;
            last_hpol_nx = ({hs_hi, 1'b0} < {1'b0, hcnt});
            de_cnt_nx    = {{(HBITS-1){1'b0}}, vga_de};
            hcnt_nx      = {{(HBITS-1){1'b0}}, 1'b1};
            hs_hi_nx     = {{(HBITS-1){1'b0}}, vga_hs};
         end else begin
            hcnt_nx = inc_h(hcnt);
            if (vga_de) de_cnt_nx = inc_h(de_cnt);
            if (vga_hs) hs_hi_nx = inc_h(hs_hi);
         end

         tcnt_nx = vs_rise ? '0 : ((&tcnt) ? tcnt : tcnt + 1'b1);

         if (vs_rise) begin
            cand.w  = max_w_nx;
            cand.h  = act_lines_nx;
            cand.ht = last_htot_nx;
            cand.vt = vlines_nx;
            cand.hp = last_hpol_nx;
            cand.vp = ({vs_hi_lines_nx, 1'b0} < {1'b0, vlines_nx});

            max_w_nx       = '0;
            act_lines_nx   = '0;
            vlines_nx      = '0;
            vs_hi_lines_nx = '0;

            if (state == S_NO_SIGNAL) begin
               state_nx     = S_ACQUIRE;
               no_signal_nx = 1'b0;
            end else begin
               if (cand == prev_cand)
                  stable_calc = (stable_cnt >= STABLE_TGT) ? STABLE_TGT : stable_cnt + 1'b1;
               else
                  stable_calc = 4'd1;
               stable_cnt_nx = stable_calc;
               prev_cand_nx  = cand;

               if (stable_calc == STABLE_TGT) begin
                  if (state == S_ACQUIRE) begin
                     state_nx       = S_LOCKED;
                     rep_nx         = cand;
                     valid_nx       = 1'b1;
                     mode_change_nx = 1'b1;
                  end else if (cand != rep) begin
                     rep_nx         = cand;
                     mode_change_nx = 1'b1;
                  end
               end
            end
         end

         if (tcnt_nx >= TMO) begin
            state_nx       = S_NO_SIGNAL;
            rep_nx         = '0;
            valid_nx       = 1'b0;
            no_signal_nx   = 1'b1;
            stable_cnt_nx  = '0;
            mode_change_nx = 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_vga_timing_analyzer.sv
// Directed bench for vga_timing_analyzer: scaled-down video modes applied from a
// table, plus hand sequences for glitch, timeout, mid-frame reset and saturation.
module tb_vga_timing_analyzer;

   logic        clk_vga = 1'b0;
   logic        resetn  = 1'b0;
   logic        vga_ce  = 1'b0;
   logic        vga_hs  = 1'b0;
   logic        vga_vs  = 1'b0;
   logic        vga_de  = 1'b0;

   logic [10:0] fb_width, h_total;
   logic [9:0]  fb_height, v_total;
   logic        hs_pol, vs_pol, fb_size_valid, mode_change, no_signal;

   logic [10:0] s_fb_width, s_h_total;
   logic [9:0]  s_fb_height, s_v_total;
   logic        s_hs_pol, s_vs_pol, s_fb_size_valid, s_mode_change, s_no_signal;

   always #5 clk_vga = ~clk_vga;

   vga_timing_analyzer #(
      .HBITS(11), .VBITS(10), .STABLE_FRAMES(3), .TIMEOUT_CYCLES(1000)
   ) dut (
      .clk_vga(clk_vga), .resetn(resetn), .vga_ce(vga_ce),
      .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_de(vga_de),
      .fb_width(fb_width), .fb_height(fb_height),
      .h_total(h_total), .v_total(v_total),
      .hs_pol(hs_pol), .vs_pol(vs_pol),
      .fb_size_valid(fb_size_valid), .mode_change(mode_change),
      .no_signal(no_signal)
   );

   // Long-timeout instance so lines wider than 2047 cycles can lock.
   vga_timing_analyzer #(
      .HBITS(11), .VBITS(10), .STABLE_FRAMES(3), .TIMEOUT_CYCLES(2000000)
   ) dut_sat (
      .clk_vga(clk_vga), .resetn(resetn), .vga_ce(vga_ce),
      .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_de(vga_de),
      .fb_width(s_fb_width), .fb_height(s_fb_height),
      .h_total(s_h_total), .v_total(s_v_total),
      .hs_pol(s_hs_pol), .vs_pol(s_vs_pol),
      .fb_size_valid(s_fb_size_valid), .mode_change(s_mode_change),
      .no_signal(s_no_signal)
   );

   typedef struct {
      int hact; int htot; int hsw; int hpol;
      int vact; int vtot; int vsw; int vpol;
      int div;
      int ew; int eh; int eht; int evt; int ehp; int evp;
   } vec_t;

   vec_t tbl[5];
   int   n_checks = 0;
   int   n_errors = 0;
   int   mc_cnt   = 0;
   int   vdrop    = 0;
   int   watch    = 0;

   always @(negedge clk_vga) begin
      if (mode_change) mc_cnt++;
      if (watch != 0 && !fb_size_valid) vdrop++;
   end

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Sync pulses sit so that both rising edges fall on pixel (0,0) of a frame.
   task automatic drive_pix(input vec_t m, input int x, input int y);
      vga_hs = (m.hpol != 0) ? (x < m.hsw) : (x < m.htot - m.hsw);
      vga_vs = (m.vpol != 0) ? (y < m.vsw) : (y < m.vtot - m.vsw);
      vga_de = (x >= 2) && (x < 2 + m.hact) && (y >= 1) && (y < 1 + m.vact);
      vga_ce = 1'b1;
      @(posedge clk_vga); #1;
      for (int k = 1; k < m.div; k++) begin
         vga_ce = 1'b0;
         @(posedge clk_vga); #1;
      end
   endtask

   task automatic send_frame(input vec_t m, input int skip0);
      for (int y = 0; y < m.vtot; y++)
         for (int x = 0; x < m.htot; x++)
            if (!(skip0 != 0 && x == 0 && y == 0)) drive_pix(m, x, y);
   endtask

   task automatic send_edge();
      vga_hs = 1'b1;
      vga_vs = 1'b1;
      vga_de = 1'b0;
      vga_ce = 1'b1;
      @(posedge clk_vga); #1;
   endtask

   task automatic ce_gap();
      vga_ce = 1'b0;
      @(posedge clk_vga); #1;
   endtask

   initial begin
      vec_t m;
      vec_t g;
      vec_t s;
      int pw, ph, pht, pvt, pvalid, mc0;

      //          hact htot hsw hp vact vtot vsw vp div  ew  eh  eht evt ehp evp
      tbl[0] = '{16,  20,  3,  0, 8,   12,  2,  0, 1,   16, 8,  20, 12, 0,  0};
      tbl[1] = '{18,  24,  4,  0, 6,   10,  2,  1, 1,   18, 6,  24, 10, 0,  1};
      tbl[2] = '{10,  14,  2,  1, 5,   9,   1,  1, 1,   10, 5,  14, 9,  1,  1};
      tbl[3] = '{320, 400, 48, 1, 1,   2,   1,  0, 2,   320, 1, 400, 2, 1,  0};
      tbl[4] = '{16,  20,  3,  0, 8,   12,  2,  0, 1,   16, 8,  20, 12, 0,  0};

      repeat (3) @(posedge clk_vga);
      #1;
      chk("rst_valid", int'(fb_size_valid), 0);
      chk("rst_no_signal", int'(no_signal), 1);
      chk("rst_mode_change", int'(mode_change), 0);
      chk("rst_width", int'(fb_width), 0);
      chk("rst_htotal", int'(h_total), 0);
      chk("rst_vtotal", int'(v_total), 0);
      resetn = 1'b1;

      pw = 0; ph = 0; pht = 0; pvt = 0; pvalid = 0;
      for (int i = 0; i < 5; i++) begin
         m   = tbl[i];
         mc0 = mc_cnt;
         send_frame(m, (i > 0) ? 1 : 0);
         send_frame(m, 0);
         send_frame(m, 0);
         chk("hold_width", int'(fb_width), pw);
         chk("hold_height", int'(fb_height), ph);
         chk("hold_htotal", int'(h_total), pht);
         chk("hold_vtotal", int'(v_total), pvt);
         chk("hold_valid", int'(fb_size_valid), pvalid);
         chk("hold_no_pulse", mc_cnt - mc0, 0);
         send_edge();
         chk("lock_width", int'(fb_width), m.ew);
         chk("lock_height", int'(fb_height), m.eh);
         chk("lock_htotal", int'(h_total), m.eht);
         chk("lock_vtotal", int'(v_total), m.evt);
         chk("lock_hs_pol", int'(hs_pol), m.ehp);
         chk("lock_vs_pol", int'(vs_pol), m.evp);
         chk("lock_valid", int'(fb_size_valid), 1);
         chk("lock_no_signal", int'(no_signal), 0);
         chk("lock_pulse", int'(mode_change), 1);
         ce_gap();
         chk("pulse_end", int'(mode_change), 0);
         chk("pulse_count", mc_cnt - mc0, 1);
         pw = m.ew; ph = m.eh; pht = m.eht; pvt = m.evt; pvalid = 1;
         watch = 1;
      end

      // One short-width frame inside locked mode must not disturb the outputs.
      m   = tbl[4];
      g   = tbl[4];
      g.hact = 15;
      mc0 = mc_cnt;
      send_frame(g, 1);
      chk("glitch_hold_width", int'(fb_width), 16);
      send_frame(m, 0);
      send_frame(m, 0);
      send_frame(m, 0);
      send_edge();
      ce_gap();
      chk("glitch_width", int'(fb_width), 16);
      chk("glitch_valid", int'(fb_size_valid), 1);
      chk("glitch_no_pulse", mc_cnt - mc0, 0);
      chk("valid_never_dropped", vdrop, 0);
      watch = 0;

      // Vsync loss: timeout fires on the 1000th ce cycle after the last edge.
      vga_hs = 1'b0; vga_vs = 1'b0; vga_de = 1'b0;
      for (int k = 0; k < 999; k++) begin
         vga_ce = 1'b1;
         @(posedge clk_vga); #1;
      end
      chk("tmo_before_no_signal", int'(no_signal), 0);
      chk("tmo_before_valid", int'(fb_size_valid), 1);
      vga_ce = 1'b1;
      @(posedge clk_vga); #1;
      chk("tmo_no_signal", int'(no_signal), 1);
      chk("tmo_valid", int'(fb_size_valid), 0);
      chk("tmo_width", int'(fb_width), 0);
      chk("tmo_height", int'(fb_height), 0);
      chk("tmo_htotal", int'(h_total), 0);
      chk("tmo_vtotal", int'(v_total), 0);
      chk("tmo_pulse", int'(mode_change), 0);

      send_frame(m, 0);
      send_frame(m, 0);
      send_frame(m, 0);
      chk("resume_before_valid", int'(fb_size_valid), 0);
      chk("resume_no_signal", int'(no_signal), 0);
      send_edge();
      chk("resume_valid", int'(fb_size_valid), 1);
      chk("resume_width", int'(fb_width), 16);
      chk("resume_vtotal", int'(v_total), 12);
      chk("resume_pulse", int'(mode_change), 1);
      ce_gap();

      // Reset in the middle of a locked frame.
      for (int k = 1; k < 100; k++) drive_pix(m, k % 20, k / 20);
      resetn = 1'b0;
      vga_ce = 1'b1;
      @(posedge clk_vga); #1;
      chk("mid_rst_valid", int'(fb_size_valid), 0);
      chk("mid_rst_no_signal", int'(no_signal), 1);
      chk("mid_rst_pulse", int'(mode_change), 0);
      chk("mid_rst_width", int'(fb_width), 0);
      resetn = 1'b1;
      send_frame(m, 0);
      send_frame(m, 0);
      send_frame(m, 0);
      chk("post_rst_before_valid", int'(fb_size_valid), 0);
      send_edge();
      chk("post_rst_valid", int'(fb_size_valid), 1);
      chk("post_rst_width", int'(fb_width), 16);
      ce_gap();

      // Line longer than the 11-bit counters: width and total pin at 2047.
      s = '{3000, 3100, 100, 0, 1, 2, 1, 0, 1, 2047, 1, 2047, 2, 0, 0};
      send_frame(s, 1);
      send_frame(s, 0);
      send_frame(s, 0);
      send_edge();
      chk("sat_width", int'(s_fb_width), s.ew);
      chk("sat_height", int'(s_fb_height), s.eh);
      chk("sat_htotal", int'(s_h_total), s.eht);
      chk("sat_vtotal", int'(s_v_total), s.evt);
      chk("sat_hs_pol", int'(s_hs_pol), s.ehp);
      chk("sat_vs_pol", int'(s_vs_pol), s.evp);
      chk("sat_valid", int'(s_fb_size_valid), 1);
      chk("sat_pulse", int'(s_mode_change), 1);
      ce_gap();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
